// File: rtl/mdu_pkg.sv
// Shared constants, op encodings, op decode helpers and FSM state type for the MDU.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH  = 32;
  localparam int unsigned MDU_STEPS  = 32;
  localparam int unsigned MDU_CNT_W  = $clog2(MDU_STEPS);
  localparam int unsigned MDU_PROD_W = 2 * MDU_WIDTH;
  localparam int unsigned MDU_OP_W   = 3;

  localparam logic [MDU_OP_W-1:0] OP_MULT  = 3'b000;
  localparam logic [MDU_OP_W-1:0] OP_MULTU = 3'b001;
  localparam logic [MDU_OP_W-1:0] OP_MADD  = 3'b010;
  localparam logic [MDU_OP_W-1:0] OP_MADDU = 3'b011;
  localparam logic [MDU_OP_W-1:0] OP_MSUB  = 3'b100;
  localparam logic [MDU_OP_W-1:0] OP_MSUBU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ACCUM = 2'd2
  } mdu_state_e;

  // Encodings 11x are reserved.
  function automatic logic is_valid_op(input logic [MDU_OP_W-1:0] op);
    return op[2:1] != 2'b11;
  endfunction

  // Even encodings are the signed variants.
  function automatic logic is_signed_op(input logic [MDU_OP_W-1:0] op);
    return !op[0];
  endfunction

  // MADD/MADDU/MSUB/MSUBU combine the product with the current HI/LO.
  function automatic logic is_accum_op(input logic [MDU_OP_W-1:0] op);
    return op[2:1] != 2'b00;
  endfunction

  function automatic logic is_sub_op(input logic [MDU_OP_W-1:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_shift_add.sv
// Iterative unsigned shift-add multiplier: one partial product per step enable.
module mdu_shift_add
  import mdu_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic [MDU_WIDTH-1:0]  i_mcand,
  input  logic [MDU_WIDTH-1:0]  i_mplier,
  output logic [MDU_PROD_W-1:0] o_product,
  output logic                  o_last_c
);

  logic [MDU_WIDTH-1:0]  r_mcand;
  logic [MDU_WIDTH-1:0]  r_mplier;
  logic [MDU_PROD_W-1:0] r_product;
  logic [MDU_CNT_W-1:0]  r_cnt;
  logic [MDU_PROD_W-1:0] w_addend;

  // Multiplicand aligned to the bit position currently being examined.
  assign w_addend  = MDU_PROD_W'(r_mcand) << r_cnt;
  assign o_last_c  = (r_cnt == MDU_CNT_W'(MDU_STEPS - 1));
  assign o_product = r_product;

  // Operand latches, product accumulator and step counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_product <= '0;
      r_cnt     <= '0;
    end else if (i_load) begin
      r_mcand   <= i_mcand;
      r_mplier  <= i_mplier;
      r_product <= '0;
      r_cnt     <= '0;
    end else if (i_step) begin
      if (r_mplier[r_cnt]) begin
        r_product <= r_product + w_addend;
      end
      r_cnt <= r_cnt + MDU_CNT_W'(1);
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multiply/divide-unit sequencer: FSM, sign fix-up, HI/LO registers and accumulation.
module mdu_sequencer
  import mdu_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [MDU_OP_W-1:0]  i_op,
  input  logic [MDU_WIDTH-1:0] i_a,
  input  logic [MDU_WIDTH-1:0] i_b,
  input  logic                 i_hi_write,
  input  logic                 i_lo_write,
  input  logic [MDU_WIDTH-1:0] i_write_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [MDU_WIDTH-1:0] o_hi,
  output logic [MDU_WIDTH-1:0] o_lo
);

  mdu_state_e            r_state;
  mdu_state_e            w_next;
  logic                  r_busy;
  logic                  r_done;
  logic [MDU_OP_W-1:0]   r_op;
  logic                  r_sign;
  logic [MDU_WIDTH-1:0]  r_hi;
  logic [MDU_WIDTH-1:0]  r_lo;

  logic                  w_load;
  logic                  w_step;
  logic                  w_accum;
  logic                  w_last;
  logic                  w_signed;
  logic                  w_sign_in;
  logic [MDU_WIDTH-1:0]  w_abs_a;
  logic [MDU_WIDTH-1:0]  w_abs_b;
  logic [MDU_PROD_W-1:0] w_product;
  logic [MDU_PROD_W-1:0] w_p;
  logic [MDU_PROD_W-1:0] w_hilo;
  logic [MDU_PROD_W-1:0] w_result;

  // Signed ops multiply magnitudes; 0x80000000 maps to 2^31 exactly as unsigned.
  assign w_signed  = is_signed_op(i_op);
  assign w_abs_a   = (w_signed && i_a[MDU_WIDTH-1]) ? MDU_WIDTH'(-i_a) : i_a;
  assign w_abs_b   = (w_signed && i_b[MDU_WIDTH-1]) ? MDU_WIDTH'(-i_b) : i_b;
  assign w_sign_in = w_signed & (i_a[MDU_WIDTH-1] ^ i_b[MDU_WIDTH-1]);

  mdu_shift_add u_shift_add (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_mcand   (w_abs_a),
    .i_mplier  (w_abs_b),
    .o_product (w_product),
    .o_last_c  (w_last)
  );

  // Sign restore and HI/LO combine, all modulo 2^64.
  assign w_p    = r_sign ? MDU_PROD_W'(-w_product) : w_product;
  assign w_hilo = {r_hi, r_lo};
  always_comb begin
    w_result = w_p;
    if (is_accum_op(r_op)) begin
      w_result = is_sub_op(r_op) ? (w_hilo - w_p) : (w_hilo + w_p);
    end
  end

  // Next-state and datapath enables.
  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_step  = 1'b0;
    w_accum = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start && is_valid_op(i_op)) begin
          w_load = 1'b1;
          w_next = S_CALC;
        end
      end
      S_CALC: begin
        w_step = 1'b1;
        if (w_last) begin
          w_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        w_accum = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register, registered status outputs and op/sign latches.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_op    <= OP_MULT;
      r_sign  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= w_accum;
      if (w_load) begin
        r_op   <= i_op;
        r_sign <= w_sign_in;
      end
    end
  end

  // HI/LO: written by mthi/mtlo only while idle, otherwise by the ACCUM step.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_accum) begin
      r_hi <= w_result[MDU_PROD_W-1:MDU_WIDTH];
      r_lo <= w_result[MDU_WIDTH-1:0];
    end else if (r_state == S_IDLE) begin
      if (i_hi_write) r_hi <= i_write_data;
      if (i_lo_write) r_lo <= i_write_data;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: vector table plus multi-cycle corner sequences.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [2:0]  i_op = 3'b000;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        i_hi_write = 1'b0;
  logic        i_lo_write = 1'b0;
  logic [31:0] i_write_data = '0;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mdu_sequencer dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_op         (i_op),
    .i_a          (i_a),
    .i_b          (i_b),
    .i_hi_write   (i_hi_write),
    .i_lo_write   (i_lo_write),
    .i_write_data (i_write_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_hi         (o_hi),
    .o_lo         (o_lo)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic        wr_same;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Idle-time mthi/mtlo of both halves.
  task automatic preload(input logic [31:0] hi, input logic [31:0] lo);
    @(negedge clk);
    i_hi_write = 1'b1; i_write_data = hi;
    @(negedge clk);
    i_hi_write = 1'b0; i_lo_write = 1'b1; i_write_data = lo;
    @(negedge clk);
    i_lo_write = 1'b0;
  endtask

  // Drive Start for one edge, then release.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    i_start = 1'b1; i_op = op; i_a = a; i_b = b;
    @(posedge clk);
    #1;
    i_start = 1'b0; i_hi_write = 1'b0; i_lo_write = 1'b0;
  endtask

  // Wait (bounded) for Done, counting Busy cycles; compare against the scoreboard head.
  task automatic wait_done(input string name, output int busy_cycles, output bit seen);
    logic [63:0] exp;
    busy_cycles = 0;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      if (o_busy) busy_cycles++;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s_timeout: no Done within 100 cycles", name);
    end else begin
      check({name, "_hilo"}, {o_hi, o_lo}, exp);
    end
  endtask

  initial begin
    int  bc;
    bit  seen;
    logic [63:0] saved;

    vecs[0] = '{OP_MULT,  32'd7,        32'hFFFFFFFD, 32'd0, 32'd0,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,        1'b0, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{OP_MADD,  32'd1,        32'd1,        32'd0, 32'hFFFFFFFF, 1'b0, 32'h00000001, 32'h00000000};
    vecs[3] = '{OP_MSUB,  32'd2,        32'd3,        32'd0, 32'd0,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[4] = '{OP_MSUBU, 32'd2,        32'd3,        32'd0, 32'd10,       1'b0, 32'h00000000, 32'h00000004};
    vecs[5] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'd0, 32'd0,        1'b0, 32'h40000000, 32'h00000000};
    vecs[6] = '{OP_MADDU, 32'hFFFFFFFF, 32'd2,        32'd1, 32'd1,        1'b0, 32'h00000002, 32'hFFFFFFFF};
    vecs[7] = '{OP_MULT,  32'hFFFFFFFF, 32'h80000000, 32'd5, 32'd5,        1'b0, 32'h00000000, 32'h80000000};
    vecs[8] = '{OP_MADD,  32'hFFFFFFFB, 32'd4,        32'd0, 32'd100,      1'b1, 32'h00000000, 32'h00000050};
    vecs[9] = '{OP_MULT,  32'h12345678, 32'd0,        32'h1, 32'h1,        1'b0, 32'h00000000, 32'h00000000};

    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_done", 64'(o_done), 64'd0);
    check("reset_hilo", {o_hi, o_lo}, 64'd0);

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].wr_same) begin
        // mtlo in the same cycle as Start: the accumulate must see the new LO.
        preload(vecs[i].pre_hi, 32'hDEADBEEF);
        i_lo_write = 1'b1; i_write_data = vecs[i].pre_lo;
      end else begin
        preload(vecs[i].pre_hi, vecs[i].pre_lo);
      end
      exp_q.push_back({vecs[i].exp_hi, vecs[i].exp_lo});
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), bc, seen);
      check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd33);
      @(negedge clk);
      check($sformatf("vec%0d_done_width", i), 64'(o_done), 64'd0);
    end

    // Reserved op: no effect.
    saved = {o_hi, o_lo};
    start_op(3'b111, 32'd3, 32'd3);
    @(negedge clk);
    check("badop_busy", 64'(o_busy), 64'd0);
    repeat (3) @(negedge clk);
    check("badop_hilo", {o_hi, o_lo}, saved);
    check("badop_done", 64'(o_done), 64'd0);

    // Start/HiWrite while busy are ignored and not queued.
    preload(32'd0, 32'd0);
    exp_q.push_back(64'd42);
    start_op(OP_MULT, 32'd7, 32'd6);
    repeat (4) @(negedge clk);
    i_start = 1'b1; i_op = OP_MULTU; i_a = 32'hFFFFFFFF; i_b = 32'hFFFFFFFF;
    i_hi_write = 1'b1; i_write_data = 32'hDEAD0000;
    @(negedge clk);
    i_start = 1'b0; i_hi_write = 1'b0;
    wait_done("busy_ignore", bc, seen);
    repeat (2) @(negedge clk);
    check("busy_ignore_no_queue", 64'(o_busy), 64'd0);

    // Back-to-back: Start in the Done cycle is accepted.
    preload(32'd0, 32'd0);
    exp_q.push_back(64'd15);
    start_op(OP_MULT, 32'd3, 32'd5);
    wait_done("b2b_first", bc, seen);
    exp_q.push_back(64'd19);
    i_start = 1'b1; i_op = OP_MADD; i_a = 32'd2; i_b = 32'd2;
    @(posedge clk);
    #1 i_start = 1'b0;
    @(negedge clk);
    check("b2b_accept_busy", 64'(o_busy), 64'd1);
    wait_done("b2b_second", bc, seen);
    check("b2b_busy_cycles", 64'(bc + 1), 64'd33);

    // Reset aborts an in-flight op without Done.
    preload(32'h11, 32'h22);
    start_op(OP_MULT, 32'd3, 32'd3);
    repeat (9) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    check("abort_busy", 64'(o_busy), 64'd0);
    check("abort_hilo", {o_hi, o_lo}, 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (o_done || o_busy) seen = 1'b1;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    check("abort_hilo_after", {o_hi, o_lo}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
